// File: rtl/led_mode_ctrl.sv
// Single-button LED controller: synchronise and debounce btn, classify short/long presses,
// step the OFF/ON/SLOW/FAST mode FSM and drive the matching blink pattern on led.
module led_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 10,
    parameter int unsigned LONG_CYC     = 500,
    parameter int unsigned SLOW_HALF    = 250,
    parameter int unsigned FAST_HALF    = 50,
    parameter int unsigned CW           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_short,
    output logic       press_long
);

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StOn   = 2'd1,
        StSlow = 2'd2,
        StFast = 2'd3
    } mode_e;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_HALF - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_HALF - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          r_sync1, r_sync2;
    logic          r_level, r_level_prev, r_armed;
    logic [CW-1:0] r_db_cnt;
    logic [CW-1:0] r_hold_cnt;
    logic          r_long_fired;
    logic          r_press_short, r_press_long;
    mode_e         r_state;
    logic [CW-1:0] r_blink_cnt;
    logic          r_led;

    logic          w_flip;
    logic          w_fall;
    mode_e         w_next;

    assign w_flip = r_armed && (r_sync2 != r_level) && (r_db_cnt == DB_LAST);
    assign w_fall = r_level_prev && !r_level;

    always_comb begin
        w_next = StOff;
        unique case (r_state)
            StOff:  w_next = StOn;
            StOn:   w_next = StSlow;
            StSlow: w_next = StFast;
            StFast: w_next = StOff;
        endcase
    end

    // Until armed, the debouncer only watches for a settled release so a press that
    // straddles reset can never be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_armed      <= 1'b0;
            r_db_cnt     <= '0;
        end else begin
            r_sync1      <= btn;
            r_sync2      <= r_sync1;
            r_level_prev <= r_level;
            if (!r_armed) begin
                if (r_sync2) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_armed  <= 1'b1;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + CNT_ONE;
                end
            end else if (r_sync2 != r_level) begin
                if (w_flip) begin
                    r_level  <= ~r_level;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + CNT_ONE;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt    <= '0;
            r_long_fired  <= 1'b0;
            r_press_short <= 1'b0;
            r_press_long  <= 1'b0;
        end else begin
            r_press_short <= w_fall && !r_long_fired;
            r_press_long  <= 1'b0;
            if (w_flip && !r_level) begin
                r_hold_cnt   <= '0;
                r_long_fired <= 1'b0;
            end else if (r_level) begin
                if (r_hold_cnt != LONG_LAST) begin
                    r_hold_cnt <= r_hold_cnt + CNT_ONE;
                end else if (!r_long_fired) begin
                    r_press_long <= 1'b1;
                    r_long_fired <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StOff;
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
        end else if (r_press_short) begin
            r_state     <= w_next;
            r_blink_cnt <= '0;
            r_led       <= (w_next != StOff);
        end else if (r_press_long) begin
            r_state     <= StOff;
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
        end else begin
            unique case (r_state)
                StOff: begin
                    r_blink_cnt <= '0;
                    r_led       <= 1'b0;
                end
                StOn: begin
                    r_blink_cnt <= '0;
                    r_led       <= 1'b1;
                end
                StSlow: begin
                    if (r_blink_cnt == SLOW_LAST) begin
                        r_blink_cnt <= '0;
                        r_led       <= ~r_led;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + CNT_ONE;
                    end
                end
                StFast: begin
                    if (r_blink_cnt == FAST_LAST) begin
                        r_blink_cnt <= '0;
                        r_led       <= ~r_led;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign led         = r_led;
    assign mode        = r_state;
    assign press_short = r_press_short;
    assign press_long  = r_press_long;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Randomised bench for led_mode_ctrl: every cycle is compared against an event-level model
// built from the raw button history (sample windows, press durations, mode entry times).
module tb_led_mode_ctrl;

    localparam int D  = 4;
    localparam int L  = 40;
    localparam int SH = 8;
    localparam int FH = 2;
    localparam int NMAX = 40000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       press_short;
    logic       press_long;

    led_mode_ctrl #(
        .DEBOUNCE_CYC(D),
        .LONG_CYC    (L),
        .SLOW_HALF   (SH),
        .FAST_HALF   (FH),
        .CW          (16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .led        (led),
        .mode       (mode),
        .press_short(press_short),
        .press_long (press_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Reference model state
    int   n = 0;
    logic raw_h [0:NMAX-1];
    int   last_rst = 0;
    logic m_lvl = 1'b0, m_armed = 1'b0, m_fell = 1'b0;
    int   m_rise = -100000, m_fall_dur = 0;
    logic m_ps = 1'b0, m_pl = 1'b0, m_led = 1'b0;
    int   m_mode = 0, m_entry = 0;
    int   dut_shorts = 0, dut_longs = 0;

    // Synchronised button value seen by the debouncer at edge k.
    function automatic logic synced(input int k);
        if (k - 2 > last_rst) return raw_h[k-2];
        return 1'b0;
    endfunction

    task automatic model_step(input logic b, input logic r);
        logic nps, npl, all0, alldiff;
        n++;
        raw_h[n] = b;
        if (r) begin
            last_rst = n;
            m_lvl = 0; m_armed = 0; m_fell = 0; m_ps = 0; m_pl = 0;
            m_mode = 0; m_led = 0; m_rise = -100000;
            return;
        end
        nps = m_fell && (m_fall_dur < L);
        npl = m_lvl && (n - m_rise == L);
        if (m_ps) begin
            m_mode = (m_mode + 1) % 4; m_entry = n;
        end else if (m_pl) begin
            m_mode = 0; m_entry = n;
        end
        all0 = (n - D + 1 > last_rst);
        alldiff = all0;
        for (int k = n - D + 1; k <= n; k++) begin
            if (k < 1 || synced(k) != 1'b0) all0 = 1'b0;
            if (k < 1 || synced(k) == m_lvl) alldiff = 1'b0;
        end
        m_fell = 0;
        if (!m_armed) begin
            if (all0) m_armed = 1;
        end else if (alldiff) begin
            m_lvl = !m_lvl;
            if (m_lvl) m_rise = n;
            else begin
                m_fell = 1; m_fall_dur = n - m_rise;
            end
        end
        m_ps = nps;
        m_pl = npl;
        case (m_mode)
            0: m_led = 1'b0;
            1: m_led = 1'b1;
            2: m_led = (((n - m_entry) / SH) % 2) == 0;
            default: m_led = (((n - m_entry) / FH) % 2) == 0;
        endcase
    endtask

    task automatic tick(input logic b, input logic r);
        @(negedge clk);
        btn = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check_eq("led", {15'd0, led}, {15'd0, m_led});
        check_eq("mode", {14'd0, mode}, 16'(m_mode));
        check_eq("press_short", {15'd0, press_short}, {15'd0, m_ps});
        check_eq("press_long", {15'd0, press_long}, {15'd0, m_pl});
        if (press_short === 1'b1) dut_shorts++;
        if (press_long === 1'b1) dut_longs++;
    endtask

    task automatic press(input int hold, input int idle);
        for (int i = 0; i < hold; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < idle; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int lat;
        // 1: reset with button held, then released
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        check_eq("rst_mode", {14'd0, mode}, 16'd0);
        check_eq("rst_led", {15'd0, led}, 16'd0);
        press($urandom_range(5, 15), 20);
        check_eq("t1_shorts", 16'(dut_shorts), 16'd0);
        check_eq("t1_longs", 16'(dut_longs), 16'd0);

        // 2: glitches shorter than the debounce window
        for (int g = 0; g < 4; g++) press($urandom_range(1, 3), $urandom_range(6, 12));
        check_eq("t2_shorts", 16'(dut_shorts), 16'd0);
        check_eq("t2_mode", {14'd0, mode}, 16'd0);

        // 3: one short press, measure release-to-mode latency
        press(12, 0);
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            tick(1'b0, 1'b0);
            if (mode == 2'd1) lat = i;
        end
        check_eq("t3_latency", 16'(lat), 16'(D + 4));
        press(0, 5);
        check_eq("t3_shorts", 16'(dut_shorts), 16'd1);
        check_eq("t3_led", {15'd0, led}, 16'd1);

        // 4: cycle through SLOW, FAST back to OFF, dwelling to see blinking
        for (int p = 0; p < 3; p++) press($urandom_range(6, 30), 40);
        check_eq("t4_mode", {14'd0, mode}, 16'd0);
        check_eq("t4_shorts", 16'(dut_shorts), 16'd4);

        // 5: long press from SLOW
        press($urandom_range(6, 20), 20);
        press($urandom_range(6, 20), 20);
        check_eq("t5_pre_mode", {14'd0, mode}, 16'd2);
        press(60, 20);
        check_eq("t5_longs", 16'(dut_longs), 16'd1);
        check_eq("t5_shorts", 16'(dut_shorts), 16'd6);
        check_eq("t5_mode", {14'd0, mode}, 16'd0);
        check_eq("t5_led", {15'd0, led}, 16'd0);

        // 6: reset in the middle of a press while in FAST
        for (int p = 0; p < 3; p++) press($urandom_range(6, 20), 15);
        check_eq("t6_pre_mode", {14'd0, mode}, 16'd3);
        press(10, 0);
        tick(1'b1, 1'b1);
        press(10, 25);
        check_eq("t6_shorts", 16'(dut_shorts), 16'd9);
        check_eq("t6_mode", {14'd0, mode}, 16'd0);
        check_eq("t6_led", {15'd0, led}, 16'd0);

        // Random presses with bounce and occasional resets
        for (int it = 0; it < 150; it++) begin
            int bounce = $urandom_range(0, 3);
            for (int j = 0; j < bounce; j++) tick(1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 24) == 0) begin
                press($urandom_range(1, 20), 0);
                tick(1'b1, 1'b1);
            end
            press($urandom_range(0, 60), $urandom_range(0, 25));
        end
        press(0, 40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
